kf_au_mc: RTL and testbench

KF_AU_MC -- requirements
Module: kf_au_mc

---
 rtl/kf_au_pkg.sv | 53 +++++
 rtl/kf_au_div.sv | 86 ++++++++
 rtl/kf_au_mc.sv | 224 ++++++++++++++++++++++
 tb/tb_kf_au_mc.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/kf_au_pkg.sv
// -----------------------------------------------------------------------------
// kf_au_pkg -- shared definitions for the kf_au_mc fixed-point arithmetic unit.
//
// Contents:
//   op_e     : op_sel encodings (ADD, SUB, MUL, DIV)
//   state_e  : controller state encoding
//   sat_t    : result of the saturate / zero-normalise step
//   sat_norm : clamps a raw magnitude to mbits bits, flags overflow, and
//              forces the sign of a zero magnitude to 0
// -----------------------------------------------------------------------------
package kf_au_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDSUB = 3'd1,
    ST_MUL    = 3'd2,
    ST_DIV    = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // Widest magnitude the helper handles, and the width of the raw input it
  // accepts (large enough for a full product or a long quotient).
  localparam int SAT_MW = 64;
  localparam int SAT_IW = 2 * SAT_MW;

  typedef struct packed {
    logic              ovf;
    logic              sign;
    logic [SAT_MW-1:0] mag;
  } sat_t;

  // Saturate a raw magnitude to mbits of all-ones, keeping the computed sign;
  // a zero magnitude always leaves with sign 0.
  function automatic sat_t sat_norm(input logic              sign,
                                    input logic [SAT_IW-1:0] mag,
                                    input int unsigned       mbits);
    sat_t              s;
    logic [SAT_IW-1:0] lim;
    lim    = (SAT_IW'(1) << mbits) - SAT_IW'(1);
    s.ovf  = (mag > lim);
    s.mag  = s.ovf ? lim[SAT_MW-1:0] : mag[SAT_MW-1:0];
    s.sign = sign & (s.mag != '0);
    return s;
  endfunction

endpackage

// File: rtl/kf_au_div.sv
// -----------------------------------------------------------------------------
// kf_au_div -- restoring divider, one quotient bit per clock.
//
// Computes (dividend << FRAC) / divisor, truncated, over W-1+FRAC cycles.
// The caller guarantees divisor != 0.
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-high reset
//   start     in   load operands and begin (ignored while running)
//   dividend  in   W-1 bit magnitude
//   divisor   in   W-1 bit magnitude
//   done      out  one-cycle pulse on the edge the last quotient bit is formed
//   quotient  out  W-1+FRAC bit quotient, stable from done until next start
// -----------------------------------------------------------------------------
module kf_au_div
  import kf_au_pkg::*;
#(
  parameter int W    = 24,
  parameter int FRAC = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [W-2:0]          dividend,
  input  logic [W-2:0]          divisor,
  output logic                  done,
  output logic [W-2+FRAC:0]     quotient
);

  localparam int M  = W - 1;
  localparam int N  = M + FRAC;
  localparam int CW = $clog2(N + 1);

  logic [M-1:0]  rem;
  logic [M-1:0]  dsr;
  logic [N-1:0]  q;
  logic [CW-1:0] cnt;
  logic          running;
  logic [M:0]    rem_sh;
  logic [M:0]    rem_diff;

  // NOTE: every signal written here gets a value on every path, so no latch.
  always_comb begin
    rem_sh   = {rem, q[N-1]};
    rem_diff = rem_sh - {1'b0, dsr};
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem     <= '0;
      dsr     <= '0;
      q       <= '0;
      cnt     <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && !running) begin
        rem     <= '0;
        dsr     <= divisor;
        q       <= {dividend, {FRAC{1'b0}}};
        cnt     <= '0;
        running <= 1'b1;
      end else if (running) begin
        // Restoring step: keep the trial subtraction only if it did not go negative.
        if (rem_sh >= {1'b0, dsr}) begin
          rem <= rem_diff[M-1:0];
          q   <= {q[N-2:0], 1'b1};
        end else begin
          rem <= rem_sh[M-1:0];
          q   <= {q[N-2:0], 1'b0};
        end
        cnt <= cnt + CW'(1);
        if (cnt == CW'(N - 1)) begin
          running <= 1'b0;
          done    <= 1'b1;
        end
      end
    end
  end

  assign quotient = q;

endmodule

// File: rtl/kf_au_mc.sv
// -----------------------------------------------------------------------------
// kf_au_mc -- multi-cycle sign-magnitude Q-format arithmetic unit.
//
// Operations (op_sel): 00 ADD, 01 SUB (a-b), 10 MUL, 11 DIV (a/b).
// Latency from the accepting edge k: ADD/SUB done at k+2, MUL at k+W,
// DIV at k+W+FRAC (divide by zero at k+2).
//
// Build option:
//   KF_AU_DIV_EN  defined   : restoring divider kf_au_div is instantiated.
//                 undefined : no divider; DIV finishes at k+2 with result 0,
//                             ovf 1.
//
// Ports:
//   clk     in   clock, rising edge
//   rst     in   asynchronous active-high reset
//   start   in   request, accepted only in IDLE
//   op_sel  in   operation code
//   a_in    in   W-bit sign-magnitude operand a
//   b_in    in   W-bit sign-magnitude operand b
//   busy    out  high whenever the unit is not IDLE
//   done    out  one-cycle completion pulse
//   result  out  registered sign-magnitude result, held until the next done
//   ovf     out  saturation / illegal-operation flag, qualified by done
// -----------------------------------------------------------------------------
module kf_au_mc
  import kf_au_pkg::*;
#(
  parameter int W    = 24,
  parameter int FRAC = 14
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   op_sel,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         ovf
);

  localparam int M  = W - 1;          // magnitude bits
  localparam int P  = 2 * M;          // full product width
  localparam int N  = M + FRAC;       // divider quotient width
  localparam int CW = $clog2(N + 1);

  state_e              state;
  op_e                 op;
  logic                a_sign;
  logic                b_sign;
  logic [M-1:0]        a_mag;
  logic [M-1:0]        b_mag;
  logic                res_sign;
  logic [P-1:0]        acc;
  logic [P-1:0]        mcand;
  logic [M-1:0]        mplier;
  logic [CW-1:0]       cnt;
  logic                eff_b_sign;
  logic [SAT_IW-1:0]   sat_in;
  sat_t                sat;

`ifdef KF_AU_DIV_EN
  logic                div_start;
  logic                div_done;
  logic                dz;
  logic [N-1:0]        div_q;

  // Launch the divider on the accepting edge so its iterations start at k+1.
  assign div_start = (state == ST_IDLE) && start && (op_sel == OP_DIV) &&
                     (b_in[M-1:0] != '0);

  kf_au_div #(
    .W    (W),
    .FRAC (FRAC)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (a_in[M-1:0]),
    .divisor  (b_in[M-1:0]),
    .done     (div_done),
    .quotient (div_q)
  );
`endif

  // SUB is ADD with b's sign flipped.
  assign eff_b_sign = b_sign ^ (op == OP_SUB);

  // Raw magnitude presented to the saturate/normalise step, per operation.
  always_comb begin
    sat_in = SAT_IW'(acc);
    unique case (state)
      ST_MUL: sat_in = SAT_IW'(acc >> FRAC);
`ifdef KF_AU_DIV_EN
      ST_DIV: sat_in = dz ? '1 : SAT_IW'(div_q);
`endif
      default: sat_in = SAT_IW'(acc);
    endcase
    sat = sat_norm(res_sign, sat_in, M);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      op       <= OP_ADD;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      ovf      <= 1'b0;
      a_sign   <= 1'b0;
      b_sign   <= 1'b0;
      a_mag    <= '0;
      b_mag    <= '0;
      res_sign <= 1'b0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      cnt      <= '0;
`ifdef KF_AU_DIV_EN
      dz       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            op       <= op_e'(op_sel);
            a_sign   <= a_in[W-1];
            b_sign   <= b_in[W-1];
            a_mag    <= a_in[M-1:0];
            b_mag    <= b_in[M-1:0];
            res_sign <= a_in[W-1] ^ b_in[W-1];
            acc      <= '0;
            mcand    <= P'(a_in[M-1:0]);
            mplier   <= b_in[M-1:0];
            cnt      <= '0;
            busy     <= 1'b1;
`ifdef KF_AU_DIV_EN
            dz       <= (b_in[M-1:0] == '0);
`endif
            unique case (op_e'(op_sel))
              OP_MUL:  state <= ST_MUL;
              OP_DIV:  state <= ST_DIV;
              default: state <= ST_ADDSUB;
            endcase
          end
        end

        // First cycle forms the raw sum/difference, second one saturates it.
        ST_ADDSUB: begin
          if (cnt == '0) begin
            cnt <= cnt + CW'(1);
            if (a_sign == eff_b_sign) begin
              acc      <= P'(a_mag) + P'(b_mag);
              res_sign <= a_sign;
            end else if (a_mag >= b_mag) begin
              acc      <= P'(a_mag - b_mag);
              res_sign <= a_sign;
            end else begin
              acc      <= P'(b_mag - a_mag);
              res_sign <= eff_b_sign;
            end
          end else begin
            result <= {sat.sign, sat.mag[M-1:0]};
            ovf    <= sat.ovf;
            done   <= 1'b1;
            state  <= ST_DONE;
          end
        end

        // One multiplier bit per cycle for M cycles, then one cycle to finish.
        ST_MUL: begin
          if (cnt < CW'(M)) begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
          end else begin
            result <= {sat.sign, sat.mag[M-1:0]};
            ovf    <= sat.ovf;
            done   <= 1'b1;
            state  <= ST_DONE;
          end
        end

        ST_DIV: begin
`ifdef KF_AU_DIV_EN
          // Divide by zero bypasses the divider and mimics ADD/SUB timing.
          if (dz ? (cnt != '0) : div_done) begin
            result <= {sat.sign, sat.mag[M-1:0]};
            ovf    <= sat.ovf;
            done   <= 1'b1;
            state  <= ST_DONE;
          end else if (dz) begin
            cnt <= cnt + CW'(1);
          end
`else
          // No divider in this build: flag the request as illegal.
          if (cnt != '0) begin
            result <= '0;
            ovf    <= 1'b1;
            done   <= 1'b1;
            state  <= ST_DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
`endif
        end

        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kf_au_mc.sv
// -----------------------------------------------------------------------------
// tb_kf_au_mc -- directed self-checking bench for kf_au_mc (W=24, FRAC=14).
// Q14 values used: 0x004000 = 1.0, 0x00A000 = 2.5, 0x00C000 = 3.0.
// Compile with +define+KF_AU_DIV_EN to exercise the divider build.
// -----------------------------------------------------------------------------
module tb_kf_au_mc;

  localparam int W    = 24;
  localparam int FRAC = 14;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op_sel;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         ovf;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  kf_au_mc #(
    .W    (W),
    .FRAC (FRAC)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op_sel (op_sel),
    .a_in   (a_in),
    .b_in   (b_in),
    .busy   (busy),
    .done   (done),
    .result (result),
    .ovf    (ovf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Waits for IDLE, issues one request, and counts edges from accept to done.
  // Called and returns #1 after a rising edge.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat);
    int guard;
    guard = 0;
    while (busy && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    op_sel = op;
    a_in   = a;
    b_in   = b;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!done && lat < 200);
  endtask

  task automatic op_check(input string tag, input logic [1:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_res, input logic exp_ovf, input int exp_lat);
    int lat;
    run_op(op, a, b, lat);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_res"}, 32'(result), 32'(exp_res));
    check({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int done_cnt;
    logic [W-1:0] held_res;

    // Reset is asynchronous: outputs must be clear before any clock edge.
    rst    = 1'b1;
    start  = 1'b0;
    op_sel = 2'b00;
    a_in   = '0;
    b_in   = '0;
    #1;
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_res",  32'(result), 32'h0);
    check("rst_ovf",  32'(ovf), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // ADD / SUB
    op_check("add",      2'b00, 24'h00C000, 24'h00A000, 24'h016000, 1'b0, 2);
    op_check("sub",      2'b01, 24'h00A000, 24'h00C000, 24'h802000, 1'b0, 2);
    op_check("add_zero", 2'b00, 24'h00C000, 24'h80C000, 24'h000000, 1'b0, 2);
    op_check("add_neg",  2'b00, 24'h80C000, 24'h00A000, 24'h802000, 1'b0, 2);
    op_check("add_sat",  2'b00, 24'h7FFFFF, 24'h000001, 24'h7FFFFF, 1'b1, 2);
    op_check("sub_nsat", 2'b01, 24'hFFFFFF, 24'h000001, 24'hFFFFFF, 1'b1, 2);

    // MUL
    op_check("mul",      2'b10, 24'h00C000, 24'h00A000, 24'h01E000, 1'b0, 24);
    op_check("mul_neg",  2'b10, 24'h80C000, 24'h00A000, 24'h81E000, 1'b0, 24);
    op_check("mul_z",    2'b10, 24'h80C000, 24'h000000, 24'h000000, 1'b0, 24);
    op_check("mul_trn",  2'b10, 24'h000001, 24'h000001, 24'h000000, 1'b0, 24);
    op_check("mul_sat",  2'b10, 24'h400000, 24'h008000, 24'h7FFFFF, 1'b1, 24);

    // Result and flag hold after done.
    held_res = result;
    repeat (3) @(posedge clk);
    #1;
    check("hold_res", 32'(result), 32'(held_res));
    check("hold_ovf", 32'(ovf), 32'h1);

    // DIV
`ifdef KF_AU_DIV_EN
    op_check("div",      2'b11, 24'h01E000, 24'h00A000, 24'h00C000, 1'b0, 38);
    op_check("div_neg",  2'b11, 24'h00A000, 24'h80C000, 24'h803555, 1'b0, 38);
    op_check("div_sat",  2'b11, 24'h400000, 24'h000001, 24'h7FFFFF, 1'b1, 38);
    op_check("div_zero", 2'b11, 24'h80C000, 24'h000000, 24'hFFFFFF, 1'b1, 2);
`else
    op_check("div_off",  2'b11, 24'h01E000, 24'h00A000, 24'h000000, 1'b1, 2);
`endif
    op_check("add_after_div", 2'b00, 24'h004000, 24'h004000, 24'h008000, 1'b0, 2);

    // start held high through MUL and the DONE cycle must be ignored.
    while (busy) begin @(posedge clk); #1; end
    op_sel = 2'b10;
    a_in   = 24'h00C000;
    b_in   = 24'h00A000;
    start  = 1'b1;
    @(posedge clk); #1;
    op_sel = 2'b00;
    a_in   = 24'h000001;
    b_in   = 24'h000001;
    lat    = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!done && lat < 200);
    check("ign_lat", 32'(lat), 32'd24);
    check("ign_res", 32'(result), 32'h01E000);
    @(posedge clk); #1;          // DONE -> IDLE with start still high
    start = 1'b0;
    check("ign_done_busy", 32'(busy), 32'h0);
    @(posedge clk); #1;
    check("ign_idle_done", 32'(done), 32'h0);

    // Reset in cycle 10 of a MUL aborts it without a done pulse.
    op_sel = 2'b10;
    a_in   = 24'h400000;
    b_in   = 24'h008000;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_done", 32'(done), 32'h0);
    check("abort_res",  32'(result), 32'h0);
    check("abort_ovf",  32'(ovf), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    done_cnt = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    check("abort_no_done", 32'(done_cnt), 32'h0);
    op_check("add_after_rst", 2'b00, 24'h00C000, 24'h00A000, 24'h016000, 1'b0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
